vx_mem_responder: RTL and testbench
===================================

# vx_mem_responder

Memory-side responder for the cache memory bus. Terminates the line-sized master port that a cache wrapper drives toward memory. It accepts read and write requests into a synthesizable line-wide backing store and returns tagged read responses after a fixed pipeline latency, with bounded buffering and credit-based backpressure. Used as an on-chip scratch memory and as a deterministic memory model for cache-level testbenches.

## Interface
- LINE_SIZE, 64, bytes per request/response line
- ADDR_WIDTH, 26, line address width
- TAG_WIDTH, 8, request tag width; echoed unchanged on responses
- MEM_LINES, 1024, backing-store depth in lines; power of two
- LATENCY, 4, request-accept to response-valid cycles; ≥ 1
- RSP_QUEUE_SIZE, 4, maximum outstanding reads; ≥ 1, power of two
- CTR_BITS, 44, perf counter width

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mem_req_valid  in  1  request valid
- mem_req_rw  in  1  1 = write, 0 = read
- mem_req_addr  in  ADDR_WIDTH  line address
- mem_req_byteen  in  LINE_SIZE  write byte enables
- mem_req_data  in  LINE_SIZE*8  write data
- mem_req_tag  in  TAG_WIDTH  request tag
- mem_req_ready  out  1  request accepted when valid && ready
- mem_rsp_valid  out  1  read response valid
- mem_rsp_data  out  LINE_SIZE*8  read data
- mem_rsp_tag  out  TAG_WIDTH  tag of the originating read
- mem_rsp_ready  in  1  response consumed when valid && ready
- perf_reads  out  CTR_BITS  accepted reads
- perf_writes  out  CTR_BITS  accepted writes

## Operation
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Indexing: line index = mem_req_addr[log2(MEM_LINES)-1:0]. Upper address bits are ignored, so addresses wrap.
- Writes:
  - On handshake, every byte b with byteen[b]=1 is updated. Bytes with byteen[b]=0 keep their contents.
  - Writes produce no response and consume no credit.
- Reads: on handshake, the line at the index is captured together with the tag. The pair travels a LATENCY-stage valid/data/tag pipeline and then enters the response FIFO of depth RSP_QUEUE_SIZE.
- Ordering:
  - Responses return strictly in read-acceptance order.
  - A read accepted in cycle N sees all writes accepted in cycles < N.
  - Only one request is accepted per cycle, so no same-cycle read/write conflict exists.
- Credits:
  - The outstanding counter (width log2(RSP_QUEUE_SIZE)+1) increments on a read handshake and decrements on a response handshake.
  - When both happen in the same cycle, the counter is unchanged.
  - mem_req_ready = (outstanding != RSP_QUEUE_SIZE), for both reads and writes. It does not depend on mem_req_valid or mem_req_rw.
  - The FIFO therefore never overflows, and the pipeline never stalls.
- Response port: mem_rsp_valid = FIFO not empty. Data and tag come from the FIFO head. While valid && !ready, the head holds stable.
- Perf counters: increment by 1 per read or write handshake and wrap modulo 2^CTR_BITS.
- Reset state:
  - Pipeline valids, FIFO pointers, outstanding, perf_reads and perf_writes are all 0.
  - mem_rsp_valid = 0 and mem_req_ready = 1.
  - Backing-store contents are not reset; they are preserved across reset and undefined after power-up.
  - Asserting reset mid-operation discards all in-flight and queued reads with no responses. Writes already accepted remain in the store.

## Timing
- Read latency: a read accepted at the rising edge ending cycle N drives mem_rsp_valid=1 in cycle N+LATENCY, provided the FIFO was empty and nothing earlier is pending.
- Throughput:
  - One request per cycle, and one response per cycle once the pipeline is filled.
  - Sustained back-to-back reads without bubbles require RSP_QUEUE_SIZE ≥ LATENCY+1 while mem_rsp_ready=1.
  - With a smaller RSP_QUEUE_SIZE, mem_req_ready deasserts when outstanding reaches RSP_QUEUE_SIZE.
- Full condition: when outstanding == RSP_QUEUE_SIZE, ready is low in that cycle. A response handshake in cycle M raises ready in cycle M+1, since ready is registered off the counter.
- Response handshake: when the FIFO is empty and a pipeline entry arrives, mem_rsp_valid rises the cycle the entry is written into the FIFO, with no extra bypass cycle.

## Test plan
- Write then read: write addr 0x10 with data pattern A5 repeated and byteen all-ones, then read addr 0x10 with tag 0x3 → rsp_data all 0xA5 and tag 0x3 at exactly LATENCY cycles after the read accept; perf_writes=1, perf_reads=1.
- Partial write: write byteen=0x...0F with data 0x11 over a line previously all 0xFF → bytes 0–3 = 0x11, remaining bytes = 0xFF.
- Backpressure: hold mem_rsp_ready=0 and issue RSP_QUEUE_SIZE+2 reads → exactly RSP_QUEUE_SIZE reads are accepted, mem_req_ready=0, and rsp data/tag stay stable. Then release → responses arrive in order with tags 0,1,2,3, and ready returns the cycle after the first response handshake.
- Wrap-around: write addr MEM_LINES+5, then read addr 5 → returns the written data.
- Streaming: with LATENCY=4, RSP_QUEUE_SIZE=8 and mem_rsp_ready=1, issue 100 back-to-back reads → 100 consecutive valid responses starting at cycle 4 with no bubbles, in order.
- Reset mid-flight: issue 3 reads, assert reset for 1 cycle before any response → no responses appear, outstanding=0, ready=1 and perf counters are 0. Then a read of a previously written line still returns the written data.

Source files
------------

// File: rtl/vx_mem_responder.sv
// vx_mem_responder: line-wide memory model terminating a cache memory port.
// Writes update the backing store under byte enables and return nothing.
// Reads capture the addressed line and tag, travel a fixed-latency pipeline,
// then wait in a response FIFO until the consumer takes them.
//
// Handshake rule (both ports): a transfer happens in a cycle exactly when
// valid && ready are both high at the rising edge. Once raised, mem_rsp_valid
// and its data/tag hold until the transfer. mem_req_ready is a function of the
// outstanding-read counter only. It never looks at mem_req_valid or
// mem_req_rw, so a master may sample it before deciding what to drive.
module vx_mem_responder #(
    parameter int LINE_SIZE      = 64,
    parameter int ADDR_WIDTH     = 26,
    parameter int TAG_WIDTH      = 8,
    parameter int MEM_LINES      = 1024,
    parameter int LATENCY        = 4,
    parameter int RSP_QUEUE_SIZE = 4,
    parameter int CTR_BITS       = 44
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_req_valid,
    input  logic                    mem_req_rw,
    input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic [LINE_SIZE-1:0]    mem_req_byteen,
    input  logic [LINE_SIZE*8-1:0]  mem_req_data,
    input  logic [TAG_WIDTH-1:0]    mem_req_tag,
    output logic                    mem_req_ready,
    output logic                    mem_rsp_valid,
    output logic [LINE_SIZE*8-1:0]  mem_rsp_data,
    output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    input  logic                    mem_rsp_ready,
    output logic [CTR_BITS-1:0]     perf_reads,
    output logic [CTR_BITS-1:0]     perf_writes
);

    localparam int DATA_W = LINE_SIZE * 8;
    localparam int IDX_W  = $clog2(MEM_LINES);
    localparam int CNT_W  = $clog2(RSP_QUEUE_SIZE) + 1;
    localparam int PTR_W  = (RSP_QUEUE_SIZE > 1) ? $clog2(RSP_QUEUE_SIZE) : 1;

    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(RSP_QUEUE_SIZE);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(RSP_QUEUE_SIZE - 1);
    localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);

    logic [DATA_W-1:0]    mem [MEM_LINES];
    logic [IDX_W-1:0]     idx;
    logic [DATA_W-1:0]    rd_line;
    logic                 req_fire;
    logic                 rd_fire;
    logic                 wr_fire;
    logic                 rsp_fire;

    logic                 fifo_in_valid;
    logic [DATA_W-1:0]    fifo_in_data;
    logic [TAG_WIDTH-1:0] fifo_in_tag;

    logic [DATA_W-1:0]    fifo_data [RSP_QUEUE_SIZE];
    logic [TAG_WIDTH-1:0] fifo_tag  [RSP_QUEUE_SIZE];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W-1:0]     outstanding;

    // Upper address bits select nothing: addresses alias modulo MEM_LINES.
    logic unused_addr;
    assign unused_addr = ^{1'b0, mem_req_addr};

    assign idx      = mem_req_addr[IDX_W-1:0];
    assign rd_line  = mem[idx];
    assign req_fire = mem_req_valid && mem_req_ready;
    assign rd_fire  = req_fire && !mem_req_rw;
    assign wr_fire  = req_fire && mem_req_rw;
    assign rsp_fire = mem_rsp_valid && mem_rsp_ready;

    // Byte-masked store update; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < LINE_SIZE; b++) begin
                if (mem_req_byteen[b]) begin
                    mem[idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
                end
            end
        end
    end

    // The FIFO write is the last of the LATENCY stages, so LATENCY-1 registers
    // sit between the read accept and the FIFO.
    generate
        if (LATENCY == 1) begin : g_direct
            assign fifo_in_valid = rd_fire;
            assign fifo_in_data  = rd_line;
            assign fifo_in_tag   = mem_req_tag;
        end else begin : g_pipe
            logic                 pipe_valid [LATENCY-1];
            logic [DATA_W-1:0]    pipe_data  [LATENCY-1];
            logic [TAG_WIDTH-1:0] pipe_tag   [LATENCY-1];

            // Valid bits shift every cycle; the pipeline never stalls.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < LATENCY - 1; i++) pipe_valid[i] <= 1'b0;
                end else begin
                    pipe_valid[0] <= rd_fire;
                    for (int i = 1; i < LATENCY - 1; i++) pipe_valid[i] <= pipe_valid[i-1];
                end
            end

            // Payload follows the valid bits; it is only meaningful where valid is set.
            always_ff @(posedge clk) begin
                pipe_data[0] <= rd_line;
                pipe_tag[0]  <= mem_req_tag;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pipe_data[i] <= pipe_data[i-1];
                    pipe_tag[i]  <= pipe_tag[i-1];
                end
            end

            assign fifo_in_valid = pipe_valid[LATENCY-2];
            assign fifo_in_data  = pipe_data[LATENCY-2];
            assign fifo_in_tag   = pipe_tag[LATENCY-2];
        end
    endgenerate

    // Response FIFO storage. Credits guarantee a free slot on every write, and
    // the head slot is never overwritten while it is occupied.
    always_ff @(posedge clk) begin
        if (fifo_in_valid) begin
            fifo_data[wr_ptr] <= fifo_in_data;
            fifo_tag[wr_ptr]  <= fifo_in_tag;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_in_valid) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            if (rsp_fire)      rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            case ({fifo_in_valid, rsp_fire})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Read credits: reads in the pipeline plus reads waiting in the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({rd_fire, rsp_fire})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Accepted-request counters, free-running and wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_reads  <= '0;
            perf_writes <= '0;
        end else begin
            if (rd_fire) perf_reads  <= perf_reads + CTR_ONE;
            if (wr_fire) perf_writes <= perf_writes + CTR_ONE;
        end
    end

    assign mem_req_ready = (outstanding != CNT_FULL);
    assign mem_rsp_valid = (fifo_count != '0);
    assign mem_rsp_data  = fifo_data[rd_ptr];
    assign mem_rsp_tag   = fifo_tag[rd_ptr];

endmodule

// File: tb/tb_vx_mem_responder.sv
// Self-checking bench for vx_mem_responder. A line-array model of the store
// and a queue of expected {tag, data} responses predict every read result.
module tb_vx_mem_responder;

    localparam int LINE_SIZE = 64;
    localparam int ADDR_W    = 26;
    localparam int TAG_W     = 8;
    localparam int MEM_LINES = 64;
    localparam int LAT       = 4;
    localparam int QSZ       = 8;   // deep enough for bubble-free streaming at LAT=4
    localparam int CTR_BITS  = 44;
    localparam int DATA_W    = LINE_SIZE * 8;
    localparam int CW        = TAG_W + DATA_W;

    logic                 clk;
    logic                 reset;
    logic                 mem_req_valid;
    logic                 mem_req_rw;
    logic [ADDR_W-1:0]    mem_req_addr;
    logic [LINE_SIZE-1:0] mem_req_byteen;
    logic [DATA_W-1:0]    mem_req_data;
    logic [TAG_W-1:0]     mem_req_tag;
    logic                 mem_req_ready;
    logic                 mem_rsp_valid;
    logic [DATA_W-1:0]    mem_rsp_data;
    logic [TAG_W-1:0]     mem_rsp_tag;
    logic                 mem_rsp_ready;
    logic [CTR_BITS-1:0]  perf_reads;
    logic [CTR_BITS-1:0]  perf_writes;

    vx_mem_responder #(
        .LINE_SIZE(LINE_SIZE), .ADDR_WIDTH(ADDR_W), .TAG_WIDTH(TAG_W),
        .MEM_LINES(MEM_LINES), .LATENCY(LAT), .RSP_QUEUE_SIZE(QSZ), .CTR_BITS(CTR_BITS)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_byteen(mem_req_byteen),
        .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
        .perf_reads(perf_reads), .perf_writes(perf_writes)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model and scoreboard state ----------------
    logic [DATA_W-1:0] model_mem [MEM_LINES];
    logic [CW-1:0]     exp_q[$];
    int                rsp_cyc_q[$];
    int                n_checks = 0;
    int                n_fail   = 0;
    int                n_reads  = 0;
    int                n_writes = 0;
    int                stalls   = 0;
    int                last_acc_cyc = 0;
    logic [DATA_W-1:0] last_rsp_data;
    logic              held = 1'b0;
    logic [CW-1:0]     held_v;

    task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_line();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Apply an accepted request to the model: writes merge bytes, reads
    // snapshot the line (all earlier writes already applied) with the tag.
    task automatic model_accept(input logic rw, input logic [ADDR_W-1:0] addr,
                                input logic [LINE_SIZE-1:0] be, input logic [DATA_W-1:0] data,
                                input logic [TAG_W-1:0] tag);
        int line;
        line = int'(addr) % MEM_LINES;
        if (rw) begin
            for (int b = 0; b < LINE_SIZE; b++)
                if (be[b]) model_mem[line][b*8 +: 8] = data[b*8 +: 8];
            n_writes++;
        end else begin
            exp_q.push_back({tag, model_mem[line]});
            n_reads++;
        end
    endtask

    // Response monitor: in-order comparison against the expected queue, plus
    // a hold check on the head whenever the consumer stalls it.
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", CW'(mem_rsp_valid), CW'(1'b1));
                check("hold_payload", {mem_rsp_tag, mem_rsp_data}, held_v);
            end
            if (mem_rsp_valid && mem_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", CW'(1'b1), CW'(1'b0));
                end else begin
                    logic [CW-1:0] e;
                    e = exp_q.pop_front();
                    check("rsp_tag", CW'(mem_rsp_tag), CW'(e[CW-1:DATA_W]));
                    check("rsp_data", CW'(mem_rsp_data), CW'(e[DATA_W-1:0]));
                end
                rsp_cyc_q.push_back(cyc);
                last_rsp_data = mem_rsp_data;
            end
            held   = mem_rsp_valid && !mem_rsp_ready;
            held_v = {mem_rsp_tag, mem_rsp_data};
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; leaves valid high so consecutive calls stream.
    task automatic do_req(input logic rw, input logic [ADDR_W-1:0] addr,
                          input logic [LINE_SIZE-1:0] be, input logic [DATA_W-1:0] data,
                          input logic [TAG_W-1:0] tag, input logic unstick);
        logic done;
        done = 1'b0;
        mem_req_valid  = 1'b1;
        mem_req_rw     = rw;
        mem_req_addr   = addr;
        mem_req_byteen = be;
        mem_req_data   = data;
        mem_req_tag    = tag;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (mem_req_ready) begin
                model_accept(rw, addr, be, data, tag);
                last_acc_cyc = cyc;
                done = 1'b1;
            end else begin
                stalls++;
                if (unstick) mem_rsp_ready = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("req_timeout", CW'(1'b0), CW'(1'b1));
    endtask

    task automatic idle(input int n);
        mem_req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int i;
        i = 0;
        mem_req_valid = 1'b0;
        while (exp_q.size() != 0 && i < 300) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("drain_empty", CW'(exp_q.size()), CW'(0));
    endtask

    // ---------------- test sequence ----------------
    logic [DATA_W-1:0] pat_a5;
    logic [DATA_W-1:0] pat_ff;
    logic [DATA_W-1:0] pat_11;
    logic [DATA_W-1:0] pat_part;
    logic [DATA_W-1:0] w69;
    logic [LINE_SIZE-1:0] be_all;

    initial begin
        int k;
        int acc;
        int base_rsp;
        int base_stall;
        int first_acc;
        int seen;
        logic [TAG_W-1:0] tg;

        pat_a5   = {LINE_SIZE{8'hA5}};
        pat_ff   = {LINE_SIZE{8'hFF}};
        pat_11   = {LINE_SIZE{8'h11}};
        pat_part = {{(LINE_SIZE-4){8'hFF}}, {4{8'h11}}};
        be_all   = '1;

        reset = 1'b1;
        mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_addr = '0;
        mem_req_byteen = '0; mem_req_data = '0; mem_req_tag = '0;
        mem_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        check("rst_ready", CW'(mem_req_ready), CW'(1'b1));
        check("rst_rsp_valid", CW'(mem_rsp_valid), CW'(1'b0));
        check("rst_perf_reads", CW'(perf_reads), CW'(0));
        check("rst_perf_writes", CW'(perf_writes), CW'(0));

        // Write then read with latency measurement
        do_req(1'b1, 26'h10, be_all, pat_a5, 8'h0, 1'b0);
        do_req(1'b0, 26'h10, '0, '0, 8'h3, 1'b0);
        mem_req_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(negedge clk);
            if (mem_rsp_valid) k = i;
        end
        check("read_latency", CW'(k), CW'(LAT));
        @(posedge clk); #1;
        check("wr_rd_data", CW'(last_rsp_data), CW'(pat_a5));
        check("perf_writes_1", CW'(perf_writes), CW'(1));
        check("perf_reads_1", CW'(perf_reads), CW'(1));

        // Partial write over an all-FF line
        do_req(1'b1, 26'h20, be_all, pat_ff, 8'h0, 1'b0);
        do_req(1'b1, 26'h20, LINE_SIZE'(64'hF), pat_11, 8'h0, 1'b0);
        do_req(1'b0, 26'h20, '0, '0, 8'h7, 1'b0);
        drain();
        idle(1);
        check("partial_data", CW'(last_rsp_data), CW'(pat_part));

        // Address wrap-around
        w69 = rand_line();
        do_req(1'b1, ADDR_W'(MEM_LINES + 5), be_all, w69, 8'h0, 1'b0);
        do_req(1'b0, 26'h5, '0, '0, 8'h9, 1'b0);
        drain();
        idle(1);
        check("wrap_data", CW'(last_rsp_data), CW'(w69));

        // Fill lines 0..15 with known random data
        for (int i = 0; i < 16; i++) do_req(1'b1, ADDR_W'(i), be_all, rand_line(), 8'h0, 1'b0);
        idle(1);

        // Streaming: 100 back-to-back reads with the consumer always ready
        base_rsp   = rsp_cyc_q.size();
        base_stall = stalls;
        first_acc  = 0;
        for (int i = 0; i < 100; i++) begin
            do_req(1'b0, ADDR_W'($urandom_range(0, 15)), '0, '0, TAG_W'(i), 1'b0);
            if (i == 0) first_acc = last_acc_cyc;
        end
        drain();
        check("stream_stalls", CW'(stalls - base_stall), CW'(0));
        check("stream_count", CW'(rsp_cyc_q.size() - base_rsp), CW'(100));
        if (rsp_cyc_q.size() - base_rsp >= 100) begin
            check("stream_first_cyc", CW'(rsp_cyc_q[base_rsp] - first_acc), CW'(LAT));
            check("stream_no_bubble", CW'(rsp_cyc_q[base_rsp + 99] - rsp_cyc_q[base_rsp]), CW'(99));
        end
        check("stream_perf_reads", CW'(perf_reads), CW'(n_reads));

        // Backpressure: QSZ+2 reads offered while the consumer is stalled
        mem_rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < QSZ + 2; i++) begin
            mem_req_valid = 1'b1; mem_req_rw = 1'b0;
            mem_req_addr = ADDR_W'(i); mem_req_tag = TAG_W'(i);
            @(negedge clk);
            if (mem_req_ready) begin
                model_accept(1'b0, ADDR_W'(i), '0, '0, TAG_W'(i));
                acc++;
            end
            @(posedge clk); #1;
        end
        mem_req_valid = 1'b0;
        check("bp_accepted", CW'(acc), CW'(QSZ));
        check("bp_ready_low", CW'(mem_req_ready), CW'(1'b0));
        idle(LAT + 3);
        check("bp_rsp_valid", CW'(mem_rsp_valid), CW'(1'b1));
        check("bp_ready_still_low", CW'(mem_req_ready), CW'(1'b0));
        mem_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_at_pop", CW'(mem_req_ready), CW'(1'b0));
        @(negedge clk);
        check("bp_ready_after_pop", CW'(mem_req_ready), CW'(1'b1));
        @(posedge clk); #1;
        drain();

        // Randomized mix of reads, writes, idles and consumer stalls
        tg = 8'h0;
        for (int i = 0; i < 300; i++) begin
            mem_rsp_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: idle(1);
                1: do_req(1'b1, ADDR_W'($urandom_range(0, 500) * MEM_LINES + $urandom_range(0, 15)),
                          {$urandom, $urandom}, rand_line(), 8'h0, 1'b1);
                default: begin
                    do_req(1'b0, ADDR_W'($urandom_range(0, 500) * MEM_LINES + $urandom_range(0, 15)),
                           '0, '0, tg, 1'b1);
                    tg = tg + 8'h1;
                end
            endcase
        end
        mem_rsp_ready = 1'b1;
        drain();
        check("rand_perf_reads", CW'(perf_reads), CW'(n_reads));
        check("rand_perf_writes", CW'(perf_writes), CW'(n_writes));
        check("rand_idle_ready", CW'(mem_req_ready), CW'(1'b1));

        // Reset with three reads in flight
        do_req(1'b0, 26'h1, '0, '0, 8'hA0, 1'b0);
        do_req(1'b0, 26'h2, '0, '0, 8'hA1, 1'b0);
        do_req(1'b0, 26'h3, '0, '0, 8'hA2, 1'b0);
        mem_req_valid = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        n_reads = 0;
        n_writes = 0;
        check("mid_rst_ready", CW'(mem_req_ready), CW'(1'b1));
        check("mid_rst_outstanding", CW'(dut.outstanding), CW'(0));
        check("mid_rst_perf_reads", CW'(perf_reads), CW'(0));
        check("mid_rst_perf_writes", CW'(perf_writes), CW'(0));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_rsp_valid) seen++;
        end
        check("mid_rst_no_rsp", CW'(seen), CW'(0));
        @(posedge clk); #1;
        do_req(1'b0, 26'h10, '0, '0, 8'h55, 1'b0);
        drain();
        idle(1);
        check("store_kept", CW'(last_rsp_data), CW'(pat_a5));
        check("post_rst_perf_reads", CW'(perf_reads), CW'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
